// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, sequencer states, AR load sources and the
// instruction timing table used by the sequencer.
package cpu_pkg;

    localparam logic [2:0] D_AND = 3'd0;
    localparam logic [2:0] D_ADD = 3'd1;
    localparam logic [2:0] D_LDA = 3'd2;
    localparam logic [2:0] D_STA = 3'd3;
    localparam logic [2:0] D_BUN = 3'd4;
    localparam logic [2:0] D_BSA = 3'd5;
    localparam logic [2:0] D_ISZ = 3'd6;
    localparam logic [2:0] D_IO  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_t;

    localparam logic [1:0] AR_NONE = 2'b00;
    localparam logic [1:0] AR_PC   = 2'b01;
    localparam logic [1:0] AR_IR   = 2'b10;
    localparam logic [1:0] AR_MEM  = 2'b11;

    localparam logic [15:0] HLT_CODE_DEFAULT = 16'h7001;

    // Final timing step (the one that clears the sequence counter) per opcode.
    function automatic logic [2:0] last_t(input logic [2:0] op);
        logic [2:0] res;
        case (op)
            D_STA, D_BUN: res = 3'd4;
            D_ISZ:        res = 3'd6;
            D_IO:         res = 3'd3;
            default:      res = 3'd5;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/t_decoder.sv
// 3-to-8 one-hot timing decoder with enable; all outputs low when disabled.
module t_decoder (
    input  logic       i_en,
    input  logic [2:0] i_sel,
    output logic [7:0] o_t
);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign o_t[gi] = i_en && (i_sel == 3'(gi));
        end
    endgenerate

endmodule

// File: rtl/seq_controller.sv
// Instruction sequencer: decodes the external timing count into fetch/decode/
// execute strobes, tracks the count with a shadow copy and flags mismatches.
module seq_controller
    import cpu_pkg::*;
#(
    parameter logic [15:0] HLT_CODE = HLT_CODE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  sc_count,
    input  logic [15:0] mem_data,
    output logic        sc_inc,
    output logic        sc_clr,
    output logic [7:0]  t,
    output logic [15:0] ir,
    output logic        ind,
    output logic [1:0]  ar_ld,
    output logic        ir_ld,
    output logic        pc_inc,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        halted,
    output logic        seq_err
);

    seq_state_t  r_state;
    seq_state_t  w_state_next;
    logic [15:0] r_ir;
    logic        r_ind;
    logic [2:0]  r_shadow;
    logic        r_seq_err;

    logic        w_run;
    logic [2:0]  w_op;
    logic        w_is_hlt;
    logic        w_sc_inc;
    logic        w_sc_clr;
    logic [1:0]  w_ar_ld;
    logic        w_ir_ld;
    logic        w_ind_ld;
    logic        w_pc_inc;
    logic        w_mem_rd;
    logic        w_mem_wr;
    logic        w_err_set;

    assign w_run    = (r_state == ST_RUN);
    assign w_op     = r_ir[14:12];
    assign w_is_hlt = (r_ir == HLT_CODE);

    t_decoder u_t_decoder (
        .i_en  (w_run),
        .i_sel (sc_count),
        .o_t   (t)
    );

    always_comb begin
        w_state_next = r_state;
        w_sc_inc     = 1'b0;
        w_sc_clr     = 1'b0;
        w_ar_ld      = AR_NONE;
        w_ir_ld      = 1'b0;
        w_ind_ld     = 1'b0;
        w_pc_inc     = 1'b0;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALTED: begin
                if (start) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                case (sc_count)
                    3'd0: w_ar_ld = AR_PC;
                    3'd1: begin
                        w_mem_rd = 1'b1;
                        w_ir_ld  = 1'b1;
                        w_pc_inc = 1'b1;
                    end
                    3'd2: begin
                        w_ar_ld  = AR_IR;
                        w_ind_ld = 1'b1;
                    end
                    3'd3: begin
                        // The halt word ends at T3 even if its opcode field is not 7.
                        if (w_op == D_IO || w_is_hlt) begin
                            w_sc_clr = 1'b1;
                            if (w_is_hlt) w_state_next = ST_HALTED;
                        end else if (r_ind) begin
                            w_mem_rd = 1'b1;
                            w_ar_ld  = AR_MEM;
                        end
                    end
                    3'd4: begin
                        if (w_op inside {D_AND, D_ADD, D_LDA, D_ISZ}) w_mem_rd = 1'b1;
                        if (w_op inside {D_STA, D_BSA})               w_mem_wr = 1'b1;
                    end
                    3'd5: ;
                    3'd6: begin
                        if (w_op == D_ISZ) w_mem_wr = 1'b1;
                    end
                    3'd7: w_sc_clr = 1'b1;
                endcase
                if (sc_count inside {3'd4, 3'd5, 3'd6} && sc_count == last_t(w_op))
                    w_sc_clr = 1'b1;
                w_sc_inc = !w_sc_clr;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_err_set = w_run && ((sc_count != r_shadow) || (sc_count == 3'd7));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ir      <= 16'h0000;
            r_ind     <= 1'b0;
            r_shadow  <= 3'd0;
            r_seq_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_ir_ld)  r_ir  <= mem_data;
            if (w_ind_ld) r_ind <= r_ir[15];
            if (w_sc_clr)      r_shadow <= 3'd0;
            else if (w_sc_inc) r_shadow <= r_shadow + 3'd1;
            if (w_err_set) r_seq_err <= 1'b1;
        end
    end

    assign sc_inc  = w_sc_inc;
    assign sc_clr  = w_sc_clr;
    assign ir      = r_ir;
    assign ind     = r_ind;
    assign ar_ld   = w_ar_ld;
    assign ir_ld   = w_ir_ld;
    assign pc_inc  = w_pc_inc;
    assign mem_rd  = w_mem_rd;
    assign mem_wr  = w_mem_wr;
    assign halted  = (r_state == ST_HALTED);
    assign seq_err = r_seq_err;

endmodule

// File: tb/tb_seq_controller.sv
// Bench for seq_controller: cycle-by-cycle vector table driven against a
// behavioural sequence counter, followed by a short hand-written sequence.
module tb_seq_controller;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  sc_count;
    logic [15:0] mem_data;
    logic        sc_inc, sc_clr;
    logic [7:0]  t;
    logic [15:0] ir;
    logic        ind;
    logic [1:0]  ar_ld;
    logic        ir_ld, pc_inc, mem_rd, mem_wr, halted, seq_err;

    logic [2:0]  r_cnt;
    logic        ovr_en;
    logic [2:0]  ovr_val;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // External sequence counter, optionally overridden to inject timing faults.
    always_ff @(posedge clk) begin
        if (reset || sc_clr) r_cnt <= 3'd0;
        else if (sc_inc)     r_cnt <= r_cnt + 3'd1;
    end
    assign sc_count = ovr_en ? ovr_val : r_cnt;

    seq_controller #(.HLT_CODE(16'h7001)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sc_count (sc_count),
        .mem_data (mem_data),
        .sc_inc   (sc_inc),
        .sc_clr   (sc_clr),
        .t        (t),
        .ir       (ir),
        .ind      (ind),
        .ar_ld    (ar_ld),
        .ir_ld    (ir_ld),
        .pc_inc   (pc_inc),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .halted   (halted),
        .seq_err  (seq_err)
    );

    typedef struct {
        logic        rst;
        logic        st;
        logic [15:0] md;
        logic [3:0]  ovr;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [18:0] e(input logic [7:0] tt, input logic inc, input logic clr,
                                      input logic [1:0] ar, input logic irld, input logic pci,
                                      input logic rd, input logic wr, input logic hlt,
                                      input logic err, input logic id);
        return {tt, inc, clr, ar, irld, pci, rd, wr, hlt, err, id};
    endfunction

    function automatic logic [18:0] fz(input logic hlt);
        return e(8'h00, 0, 0, 2'b00, 0, 0, 0, 0, hlt, 0, 0);
    endfunction
    function automatic logic [18:0] ft0(input logic err, input logic id);
        return e(8'h01, 1, 0, 2'b01, 0, 0, 0, 0, 0, err, id);
    endfunction
    function automatic logic [18:0] ft1(input logic err, input logic id);
        return e(8'h02, 1, 0, 2'b00, 1, 1, 1, 0, 0, err, id);
    endfunction
    function automatic logic [18:0] ft2(input logic err, input logic id);
        return e(8'h04, 1, 0, 2'b10, 0, 0, 0, 0, 0, err, id);
    endfunction

    task automatic add(input logic rst, input logic st, input logic [15:0] md,
                       input logic [3:0] ovr, input logic [18:0] ex);
        vecs.push_back('{rst, st, md, ovr, ex});
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    localparam logic [3:0] N = 4'h0;

    initial begin
        logic [18:0] act;

        // LDA direct
        add(0, 0, 16'h0000, N, fz(0));
        add(0, 1, 16'h0000, N, fz(0));
        add(0, 0, 16'h2010, N, ft0(0, 0));
        add(0, 0, 16'h2010, N, ft1(0, 0));
        add(0, 0, 16'h2010, N, ft2(0, 0));
        add(0, 0, 16'h2010, N, e(8'h08, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 16'h2010, N, e(8'h10, 1, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0));
        add(0, 0, 16'h2010, N, e(8'h20, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        // LDA indirect
        add(0, 0, 16'hA010, N, ft0(0, 0));
        add(0, 0, 16'hA010, N, ft1(0, 0));
        add(0, 0, 16'hA010, N, ft2(0, 0));
        add(0, 0, 16'hA010, N, e(8'h08, 1, 0, 2'b11, 0, 0, 1, 0, 0, 0, 1));
        add(0, 0, 16'hA010, N, e(8'h10, 1, 0, 2'b00, 0, 0, 1, 0, 0, 0, 1));
        add(0, 0, 16'hA010, N, e(8'h20, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 1));
        // ISZ
        add(0, 0, 16'h6020, N, ft0(0, 1));
        add(0, 0, 16'h6020, N, ft1(0, 1));
        add(0, 0, 16'h6020, N, ft2(0, 1));
        add(0, 0, 16'h6020, N, e(8'h08, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 16'h6020, N, e(8'h10, 1, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0));
        add(0, 0, 16'h6020, N, e(8'h20, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 16'h6020, N, e(8'h40, 0, 1, 2'b00, 0, 0, 0, 1, 0, 0, 0));
        // STA
        add(0, 0, 16'h3020, N, ft0(0, 0));
        add(0, 0, 16'h3020, N, ft1(0, 0));
        add(0, 0, 16'h3020, N, ft2(0, 0));
        add(0, 0, 16'h3020, N, e(8'h08, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 16'h3020, N, e(8'h10, 0, 1, 2'b00, 0, 0, 0, 1, 0, 0, 0));
        // HLT, then restart with start
        add(0, 0, 16'h7001, N, ft0(0, 0));
        add(0, 0, 16'h7001, N, ft1(0, 0));
        add(0, 0, 16'h7001, N, ft2(0, 0));
        add(0, 0, 16'h7001, N, e(8'h08, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 16'h7001, N, fz(1));
        add(0, 1, 16'h7001, N, fz(1));
        // BUN, with a start pulse in RUN that must be ignored
        add(0, 0, 16'h4100, N, ft0(0, 0));
        add(0, 1, 16'h4100, N, ft1(0, 0));
        add(0, 0, 16'h4100, N, ft2(0, 0));
        add(0, 0, 16'h4100, N, e(8'h08, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 16'h4100, N, e(8'h10, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        // BSA
        add(0, 0, 16'h5010, N, ft0(0, 0));
        add(0, 0, 16'h5010, N, ft1(0, 0));
        add(0, 0, 16'h5010, N, ft2(0, 0));
        add(0, 0, 16'h5010, N, e(8'h08, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 16'h5010, N, e(8'h10, 1, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0));
        add(0, 0, 16'h5010, N, e(8'h20, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        // HLT with start in the halting T3: halt wins
        add(0, 0, 16'h7001, N, ft0(0, 0));
        add(0, 0, 16'h7001, N, ft1(0, 0));
        add(0, 0, 16'h7001, N, ft2(0, 0));
        add(0, 1, 16'h7001, N, e(8'h08, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 16'h7001, N, fz(1));
        add(0, 1, 16'h7001, N, fz(1));
        // Register-reference (D=7, not halt): completes at T3, stays in RUN
        add(0, 0, 16'h7800, N, ft0(0, 0));
        add(0, 0, 16'h7800, N, ft1(0, 0));
        add(0, 0, 16'h7800, N, ft2(0, 0));
        add(0, 0, 16'h7800, N, e(8'h08, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 16'h2010, N, ft0(0, 0));
        // Reset during T1
        add(1, 0, 16'h2010, N, ft1(0, 0));
        add(0, 0, 16'h2010, N, fz(0));
        add(0, 1, 16'h2010, N, fz(0));
        add(0, 0, 16'h2010, N, ft0(0, 0));
        // Count forced to 3 where T1 was due: ir stays 0, seq_err sticks
        add(0, 0, 16'h2010, 4'b1011, e(8'h08, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 16'h2010, N, ft2(1, 0));
        add(0, 0, 16'h2010, N, e(8'h08, 1, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0));
        add(0, 0, 16'h2010, N, e(8'h10, 1, 0, 2'b00, 0, 0, 1, 0, 0, 1, 0));
        add(0, 0, 16'h2010, N, e(8'h20, 0, 1, 2'b00, 0, 0, 0, 0, 0, 1, 0));
        add(0, 0, 16'h2010, N, ft0(1, 0));
        add(0, 0, 16'h2010, N, ft1(1, 0));
        add(0, 0, 16'h2010, N, ft2(1, 0));
        add(0, 0, 16'h2010, N, e(8'h08, 1, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0));
        add(1, 0, 16'h2010, N, e(8'h10, 1, 0, 2'b00, 0, 0, 1, 0, 0, 1, 0));
        add(0, 0, 16'h2010, N, fz(0));
        // Illegal T7 in RUN
        add(0, 1, 16'h2010, N, fz(0));
        add(0, 0, 16'h2010, N, ft0(0, 0));
        add(0, 0, 16'h2010, 4'b1111, e(8'h80, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 16'h2010, N, ft0(1, 0));

        reset    = 1'b1;
        start    = 1'b0;
        mem_data = 16'h0000;
        ovr_en   = 1'b0;
        ovr_val  = 3'd0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            reset    = vecs[i].rst;
            start    = vecs[i].st;
            mem_data = vecs[i].md;
            ovr_en   = vecs[i].ovr[3];
            ovr_val  = vecs[i].ovr[2:0];
            @(negedge clk);
            act = {t, sc_inc, sc_clr, ar_ld, ir_ld, pc_inc, mem_rd, mem_wr, halted, seq_err, ind};
            $display("vec%0d rst=%b st=%b md=%h cnt=%0d out=%b", i, reset, start, mem_data,
                     sc_count, act);
            chk($sformatf("vec%0d", i), {13'd0, act}, {13'd0, vecs[i].exp});
        end

        // ADD indirect: check the latched ir and ind values directly
        @(posedge clk); #1 reset = 1'b1; start = 1'b0; ovr_en = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ir", {16'd0, ir}, 32'h0000);
        chk("rst_ind_halted", {30'd0, ind, halted}, 32'd0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 mem_data = 16'h9234;
        @(negedge clk);
        chk("add_t1_irld", {31'd0, ir_ld}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("add_t2_ir", {16'd0, ir}, 32'h9234);
        chk("add_t2_ind", {31'd0, ind}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("add_t3_ind_rd_ar", {28'd0, ind, mem_rd, ar_ld}, {28'd0, 4'b1111});
        @(posedge clk); #1;
        @(negedge clk);
        chk("add_t4_t_rd", {23'd0, t, mem_rd}, {23'd0, 8'h10, 1'b1});
        @(posedge clk); #1;
        @(negedge clk);
        chk("add_t5_clr_inc", {30'd0, sc_clr, sc_inc}, {30'd0, 2'b10});
        $display("hand sequence done ir=%h t=%h", ir, t);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 The block SHALL have parameter HLT_CODE, default 16'h7001, meaning the instruction word that halts the sequencer.
REQ-002 The block SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset: synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1, one-cycle pulse that begins or resumes instruction execution.
REQ-005 The block SHALL have port sc_count, input, 3, current timing count from the sequence counter.
REQ-006 The block SHALL have port mem_data, input, 16, memory read data.
REQ-007 The block SHALL have port sc_inc, output, 1, increment request to the sequence counter.
REQ-008 The block SHALL have port sc_clr, output, 1, clear request to the sequence counter, at end of instruction.
REQ-009 The block SHALL have port t, output, 8, one-hot decode of sc_count (T0..T7), forced to 0 unless in RUN.
REQ-010 The block SHALL have the following output ports:
- ir, output, 16, latched instruction.
- ind, output, 1, latched indirect bit.
- ar_ld, output, 2, AR load source (00 none, 01 PC, 10 IR[11:0], 11 mem_data[11:0]).
- ir_ld, output, 1, IR load strobe.
- pc_inc, output, 1, PC increment strobe.
- mem_rd, output, 1, memory read strobe.
- mem_wr, output, 1, memory write strobe.
- halted, output, 1, sequencer is in HALTED.
- seq_err, output, 1, sticky timing mismatch flag.

Function
REQ-011 The block SHALL implement states IDLE, RUN and HALTED.
- IDLE -> RUN on start.
- RUN -> HALTED at T3 when ir==HLT_CODE.
- HALTED -> RUN on start.
- start in RUN SHALL be ignored.
REQ-012 In IDLE and HALTED, all strobes, sc_inc, sc_clr and t SHALL be 0.
REQ-013 Strobes SHALL be combinational from state, sc_count and the latched ir/ind, asserted in the same cycle as the decoded T.
REQ-014 The fetch phase SHALL drive the following:
- T0: ar_ld=01.
- T1: mem_rd=1, ir_ld=1, pc_inc=1; ir<=mem_data at the clock edge.
REQ-015 At T2, the block SHALL drive ar_ld=10 and latch ind<=ir[15]; the opcode is D=ir[14:12].
REQ-016 At T3 with D!=7 and ind=1, the block SHALL drive mem_rd=1 and ar_ld=11; at T3 with D!=7 and ind=0, it SHALL drive no strobe.
REQ-017 At T3 with D==7, the instruction SHALL complete: sc_clr=1, and the block SHALL enter HALTED if ir==HLT_CODE.
REQ-018 The last T for memory-reference opcodes, at which sc_clr=1, SHALL be as follows:
- AND(0), ADD(1), LDA(2): T5, with mem_rd=1 at T4.
- STA(3): T4, with mem_wr=1 at T4.
- BUN(4): T4.
- BSA(5): T5, with mem_wr=1 at T4.
- ISZ(6): T6, with mem_rd=1 at T4 and mem_wr=1 at T6.
REQ-019 In RUN, sc_inc SHALL be 1 on every cycle where sc_clr is 0, and sc_inc and sc_clr SHALL never both be 1.
REQ-020 The block SHALL keep an internal 3-bit shadow count that follows its own sc_inc/sc_clr, and SHALL set seq_err when sc_count!=shadow in RUN; seq_err SHALL stay set until reset.
REQ-021 A T7 reached in RUN is illegal: the block SHALL set seq_err and drive sc_clr=1.
REQ-022 If start and the halting T3 occur in the same cycle, the block SHALL enter HALTED.

Reset
REQ-023 When reset=1 at a clock edge, the block SHALL set state=IDLE, ir=0, ind=0, shadow=0 and seq_err=0, making halted=0 and all strobes 0.
REQ-024 Reset SHALL override start and any in-progress instruction; the sequence counter is cleared by the same reset.

Structure
REQ-025 The following SHALL reside in shared package cpu_pkg:
- opcode constants D_AND..D_IO.
- state enum.
- ar_ld source encodings.
- HLT_CODE default.
REQ-026 The one-hot timing decoder SHALL be a sub-module named t_decoder (3-to-8, with enable).

Verification
REQ-027 Scenario 1: reset, then start, with mem_data=16'h2010 (LDA direct) -> t=01,02,04,08,10,20; mem_rd at T1 and T4; sc_clr at T5; next cycle t=01.
REQ-028 Scenario 2: mem_data=16'hA010 (LDA indirect) -> ind=1 after T2; at T3 mem_rd=1 and ar_ld=11.
REQ-029 Scenario 3: mem_data=16'h6020 (ISZ) -> mem_wr=1 only at T6, sc_clr at T6; mem_data=16'h3020 (STA) -> mem_wr=1 and sc_clr both at T4.
REQ-030 Scenario 4: mem_data=16'h7001 -> sc_clr at T3, halted=1, t=0 thereafter; start -> next fetch begins at T0.
REQ-031 Scenario 5: sc_count forced to 3 during expected T1 -> seq_err=1 and stays 1 until reset; reset asserted mid-T4 -> IDLE with all outputs 0 next cycle.
